// File: rtl/pe_mac_dbuf.sv
// Weight-stationary systolic PE: double-buffered weight, two-stage signed/unsigned MAC,
// pass-through (WS) or local accumulate-and-emit (ACC) psum, optional saturation.
module pe_mac_dbuf #(
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 32,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_signed_i,
    input  logic                  cfg_mode_i,
    input  logic [DATA_WIDTH-1:0] weight_i,
    input  logic                  weight_load_i,
    input  logic                  weight_swap_i,
    output logic [DATA_WIDTH-1:0] weight_o,
    output logic                  weight_load_o,
    output logic                  weight_swap_o,
    input  logic [DATA_WIDTH-1:0] ifmap_i,
    input  logic                  ifmap_valid_i,
    input  logic                  ifmap_last_i,
    output logic [DATA_WIDTH-1:0] ifmap_o,
    output logic                  ifmap_valid_o,
    output logic                  ifmap_last_o,
    input  logic [PSUM_WIDTH-1:0] psum_i,
    input  logic                  psum_valid_i,
    output logic [PSUM_WIDTH-1:0] psum_o,
    output logic                  psum_valid_o,
    output logic                  ovf_o
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int P  = PSUM_WIDTH;

    typedef enum logic {
        ACC_IDLE,
        ACC_RUN
    } acc_state_t;

    // Forwarding registers
    logic [DATA_WIDTH-1:0] r_weight_fwd;
    logic                  r_weight_load_fwd;
    logic                  r_weight_swap_fwd;
    logic [DATA_WIDTH-1:0] r_ifmap_fwd;
    logic                  r_ifmap_valid_fwd;
    logic                  r_ifmap_last_fwd;

    // Weight double buffer
    logic [DATA_WIDTH-1:0] r_shadow;
    logic [DATA_WIDTH-1:0] r_active;

    // Stage 1
    logic                  r_s1_valid;
    logic                  r_s1_last;
    logic                  r_s1_signed;
    logic                  r_s1_mode;
    logic [PW-1:0]         r_s1_prod;
    logic [P-1:0]          r_s1_psum;

    // Stage 2 / accumulator
    acc_state_t            r_state;
    logic [P-1:0]          r_acc;
    logic [P-1:0]          r_psum;
    logic                  r_psum_valid;
    logic                  r_ovf;

    logic [PW-1:0]         w_ifmap_sx;
    logic [PW-1:0]         w_weight_sx;
    logic [PW-1:0]         w_ifmap_zx;
    logic [PW-1:0]         w_weight_zx;
    logic [PW-1:0]         w_prod_s;
    logic [PW-1:0]         w_prod_u;
    logic [PW-1:0]         w_prod;

    logic [P:0]            w_prod_x;
    logic [P-1:0]          w_addend;
    logic [P:0]            w_add_x;
    logic [P:0]            w_sum;
    logic                  w_ovf;
    logic [P-1:0]          w_sat;
    logic [P-1:0]          w_result;

    // Unconditional one-cycle daisy chain gives the array its one-cycle-per-PE skew
    always_ff @(posedge clk) begin
        if (rst) begin
            r_weight_fwd      <= '0;
            r_weight_load_fwd <= 1'b0;
            r_weight_swap_fwd <= 1'b0;
            r_ifmap_fwd       <= '0;
            r_ifmap_valid_fwd <= 1'b0;
            r_ifmap_last_fwd  <= 1'b0;
        end else begin
            r_weight_fwd      <= weight_i;
            r_weight_load_fwd <= weight_load_i;
            r_weight_swap_fwd <= weight_swap_i;
            r_ifmap_fwd       <= ifmap_i;
            r_ifmap_valid_fwd <= ifmap_valid_i;
            r_ifmap_last_fwd  <= ifmap_last_i;
        end
    end

    // Simultaneous load and swap: active takes the old shadow, shadow takes weight_i
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (weight_swap_i) begin
                r_active <= r_shadow;
            end
            if (weight_load_i) begin
                r_shadow <= weight_i;
            end
        end
    end

    // Operands widened to the product width so the low PW bits are exact either way
    assign w_ifmap_sx  = {{DATA_WIDTH{ifmap_i[DATA_WIDTH-1]}}, ifmap_i};
    assign w_weight_sx = {{DATA_WIDTH{r_active[DATA_WIDTH-1]}}, r_active};
    assign w_ifmap_zx  = {{DATA_WIDTH{1'b0}}, ifmap_i};
    assign w_weight_zx = {{DATA_WIDTH{1'b0}}, r_active};
    assign w_prod_s    = w_ifmap_sx * w_weight_sx;
    assign w_prod_u    = w_ifmap_zx * w_weight_zx;
    assign w_prod      = cfg_signed_i ? w_prod_s : w_prod_u;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_signed <= 1'b0;
            r_s1_mode   <= 1'b0;
            r_s1_prod   <= '0;
            r_s1_psum   <= '0;
        end else begin
            r_s1_valid <= ifmap_valid_i;
            if (ifmap_valid_i) begin
                r_s1_last   <= ifmap_last_i;
                r_s1_signed <= cfg_signed_i;
                r_s1_mode   <= cfg_mode_i;
                r_s1_prod   <= w_prod;
                r_s1_psum   <= psum_valid_i ? psum_i : '0;
            end
        end
    end

    // One extra bit of headroom exposes signed overflow and unsigned carry-out
    assign w_prod_x = r_s1_signed ? {{(P + 1 - PW){r_s1_prod[PW-1]}}, r_s1_prod}
                                  : {{(P + 1 - PW){1'b0}}, r_s1_prod};
    assign w_addend = r_s1_mode ? ((r_state == ACC_RUN) ? r_acc : '0) : r_s1_psum;
    assign w_add_x  = {r_s1_signed & w_addend[P-1], w_addend};
    assign w_sum    = w_prod_x + w_add_x;
    assign w_ovf    = r_s1_signed ? (w_sum[P] ^ w_sum[P-1]) : w_sum[P];
    assign w_sat    = r_s1_signed ? (w_sum[P] ? {1'b1, {(P-1){1'b0}}} : {1'b0, {(P-1){1'b1}}})
                                  : {P{1'b1}};
    assign w_result = ((SATURATE != 0) && w_ovf) ? w_sat : w_sum[P-1:0];

    // A WS sample arriving during an open ACC run drops the partial sum silently
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ACC_IDLE;
            r_acc        <= '0;
            r_psum       <= '0;
            r_psum_valid <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_psum_valid <= 1'b0;
            if (r_s1_valid) begin
                if (w_ovf) begin
                    r_ovf <= 1'b1;
                end
                if (!r_s1_mode || r_s1_last) begin
                    r_psum       <= w_result;
                    r_psum_valid <= 1'b1;
                    r_state      <= ACC_IDLE;
                    r_acc        <= '0;
                end else begin
                    r_acc   <= w_result;
                    r_state <= ACC_RUN;
                end
            end
        end
    end

    assign weight_o      = r_weight_fwd;
    assign weight_load_o = r_weight_load_fwd;
    assign weight_swap_o = r_weight_swap_fwd;
    assign ifmap_o       = r_ifmap_fwd;
    assign ifmap_valid_o = r_ifmap_valid_fwd;
    assign ifmap_last_o  = r_ifmap_last_fwd;
    assign psum_o        = r_psum;
    assign psum_valid_o  = r_psum_valid;
    assign ovf_o         = r_ovf;

endmodule

// File: tb/tb_pe_mac_dbuf.sv
// Bench for pe_mac_dbuf: three instances (32-bit wrap, 16-bit saturate, 16-bit wrap)
// driven in lockstep and compared every cycle against an arithmetic reference model.
module tb_pe_mac_dbuf;

    localparam int NI = 3;

    logic        clk;
    logic        rst;
    logic        cfgSigned;
    logic        cfgMode;
    logic [7:0]  weightIn;
    logic        weightLoad;
    logic        weightSwap;
    logic [7:0]  ifmapIn;
    logic        ifmapValid;
    logic        ifmapLast;
    logic [31:0] psumIn;
    logic        psumValidIn;

    logic [7:0]  weightOut;
    logic        weightLoadOut;
    logic        weightSwapOut;
    logic [7:0]  ifmapOut;
    logic        ifmapValidOut;
    logic        ifmapLastOut;

    logic [31:0] psumOut0;
    logic [15:0] psumOut1;
    logic [15:0] psumOut2;
    logic        psumValidOut[NI];
    logic        ovfOut[NI];

    logic [7:0]  unusedWeight1, unusedWeight2, unusedIfmap1, unusedIfmap2;
    logic        unusedFlags1[4];
    logic        unusedFlags2[4];

    int nVec = 0;
    int nMis = 0;

    // Reference model state
    logic [7:0]  mActive, mShadow;
    bit          mRun[NI];
    longint      mAcc[NI];
    bit          mOvf[NI];
    bit          pValid, pSgn, pMode, pLast, pPsumV;
    logic [7:0]  pX, pW;
    logic [31:0] pPsum;

    pe_mac_dbuf #(.DATA_WIDTH(8), .PSUM_WIDTH(32), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .cfg_signed_i(cfgSigned), .cfg_mode_i(cfgMode),
        .weight_i(weightIn), .weight_load_i(weightLoad), .weight_swap_i(weightSwap),
        .weight_o(weightOut), .weight_load_o(weightLoadOut), .weight_swap_o(weightSwapOut),
        .ifmap_i(ifmapIn), .ifmap_valid_i(ifmapValid), .ifmap_last_i(ifmapLast),
        .ifmap_o(ifmapOut), .ifmap_valid_o(ifmapValidOut), .ifmap_last_o(ifmapLastOut),
        .psum_i(psumIn), .psum_valid_i(psumValidIn),
        .psum_o(psumOut0), .psum_valid_o(psumValidOut[0]), .ovf_o(ovfOut[0])
    );

    pe_mac_dbuf #(.DATA_WIDTH(8), .PSUM_WIDTH(16), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .cfg_signed_i(cfgSigned), .cfg_mode_i(cfgMode),
        .weight_i(weightIn), .weight_load_i(weightLoad), .weight_swap_i(weightSwap),
        .weight_o(unusedWeight1), .weight_load_o(unusedFlags1[0]), .weight_swap_o(unusedFlags1[1]),
        .ifmap_i(ifmapIn), .ifmap_valid_i(ifmapValid), .ifmap_last_i(ifmapLast),
        .ifmap_o(unusedIfmap1), .ifmap_valid_o(unusedFlags1[2]), .ifmap_last_o(unusedFlags1[3]),
        .psum_i(psumIn[15:0]), .psum_valid_i(psumValidIn),
        .psum_o(psumOut1), .psum_valid_o(psumValidOut[1]), .ovf_o(ovfOut[1])
    );

    pe_mac_dbuf #(.DATA_WIDTH(8), .PSUM_WIDTH(16), .SATURATE(0)) dut2 (
        .clk(clk), .rst(rst), .cfg_signed_i(cfgSigned), .cfg_mode_i(cfgMode),
        .weight_i(weightIn), .weight_load_i(weightLoad), .weight_swap_i(weightSwap),
        .weight_o(unusedWeight2), .weight_load_o(unusedFlags2[0]), .weight_swap_o(unusedFlags2[1]),
        .ifmap_i(ifmapIn), .ifmap_valid_i(ifmapValid), .ifmap_last_i(ifmapLast),
        .ifmap_o(unusedIfmap2), .ifmap_valid_o(unusedFlags2[2]), .ifmap_last_o(unusedFlags2[3]),
        .psum_i(psumIn[15:0]), .psum_valid_i(psumValidIn),
        .psum_o(psumOut2), .psum_valid_o(psumValidOut[2]), .ovf_o(ovfOut[2])
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck run still terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] timeout");
    end

    function automatic int widthOf(input int i);
        return (i == 0) ? 32 : 16;
    endfunction

    function automatic int satOf(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic logic [31:0] psumOf(input int i);
        case (i)
            0:       return psumOut0;
            1:       return {16'h0, psumOut1};
            default: return {16'h0, psumOut2};
        endcase
    endfunction

    // Interpret a p-bit pattern as a signed or unsigned integer
    function automatic longint interp(input longint pat, input int p, input bit sgn);
        longint m;
        m = longint'(1) << p;
        pat = pat & (m - 1);
        if (sgn && pat[p-1]) return pat - m;
        return pat;
    endfunction

    // Exact integer sum, then clamp or wrap into the p-bit range
    task automatic modelAdd(input int p, input int satOn, input longint a, input longint b,
                            input bit sgn, output longint res, output bit ov);
        longint s, hi, lo, m;
        m  = longint'(1) << p;
        s  = a + b;
        hi = sgn ? (m / 2 - 1) : (m - 1);
        lo = sgn ? -(m / 2) : 0;
        ov = (s > hi) || (s < lo);
        if (ov && satOn != 0) s = (s > hi) ? hi : lo;
        res = s & (m - 1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nVec++;
        assert (observed === expected)
        else begin
            nMis++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        cfgSigned   = 1'b0;
        cfgMode     = 1'b0;
        weightIn    = 8'h0;
        weightLoad  = 1'b0;
        weightSwap  = 1'b0;
        ifmapIn     = 8'h0;
        ifmapValid  = 1'b0;
        ifmapLast   = 1'b0;
        psumIn      = 32'h0;
        psumValidIn = 1'b0;
    endtask

    // Clock one edge with the currently driven inputs, then check every output against the model
    task automatic applyStimulus();
        longint prod, addend, res;
        bit     ov, expV;
        int     p;
        @(posedge clk);
        #1;
        if (rst) begin
            mActive = 8'h0;
            mShadow = 8'h0;
            pValid  = 1'b0;
            for (int i = 0; i < NI; i++) begin
                mRun[i] = 1'b0;
                mAcc[i] = 0;
                mOvf[i] = 1'b0;
                checkOutput($sformatf("reset_psum[%0d]", i), psumOf(i), 32'h0);
                checkOutput($sformatf("reset_valid[%0d]", i), {31'h0, psumValidOut[i]}, 32'h0);
                checkOutput($sformatf("reset_ovf[%0d]", i), {31'h0, ovfOut[i]}, 32'h0);
            end
            checkOutput("reset_fwd", {8'h0, weightOut, ifmapOut, 3'h0, weightLoadOut,
                        weightSwapOut, ifmapValidOut, ifmapLastOut, 1'b0}, 32'h0);
            return;
        end
        checkOutput("weight_o", {24'h0, weightOut}, {24'h0, weightIn});
        checkOutput("ifmap_o", {24'h0, ifmapOut}, {24'h0, ifmapIn});
        checkOutput("fwd_flags", {28'h0, weightLoadOut, weightSwapOut, ifmapValidOut, ifmapLastOut},
                    {28'h0, weightLoad, weightSwap, ifmapValid, ifmapLast});
        for (int i = 0; i < NI; i++) begin
            p    = widthOf(i);
            expV = 1'b0;
            res  = 0;
            ov   = 1'b0;
            if (pValid) begin
                prod = pSgn ? longint'($signed(pX)) * longint'($signed(pW))
                            : longint'(pX) * longint'(pW);
                if (!pMode) begin
                    addend = pPsumV ? interp(longint'(pPsum), p, pSgn) : 0;
                    modelAdd(p, satOf(i), prod, addend, pSgn, res, ov);
                    expV    = 1'b1;
                    mRun[i] = 1'b0;
                    mAcc[i] = 0;
                end else begin
                    addend = mRun[i] ? interp(mAcc[i], p, pSgn) : 0;
                    modelAdd(p, satOf(i), prod, addend, pSgn, res, ov);
                    if (pLast) begin
                        expV    = 1'b1;
                        mRun[i] = 1'b0;
                        mAcc[i] = 0;
                    end else begin
                        mRun[i] = 1'b1;
                        mAcc[i] = res;
                    end
                end
                if (ov) mOvf[i] = 1'b1;
            end
            checkOutput($sformatf("psum_valid_o[%0d]", i), {31'h0, psumValidOut[i]}, {31'h0, expV});
            if (expV) checkOutput($sformatf("psum_o[%0d]", i), psumOf(i), 32'(res));
            checkOutput($sformatf("ovf_o[%0d]", i), {31'h0, ovfOut[i]}, {31'h0, mOvf[i]});
        end
        pValid = ifmapValid;
        pX     = ifmapIn;
        pW     = mActive;
        pSgn   = cfgSigned;
        pMode  = cfgMode;
        pLast  = ifmapLast;
        pPsum  = psumIn;
        pPsumV = psumValidIn;
        if (weightSwap) mActive = mShadow;
        if (weightLoad) mShadow = weightIn;
    endtask

    task automatic loadAndSwap(input logic [7:0] w);
        weightIn   = w;
        weightLoad = 1'b1;
        applyStimulus();
        weightLoad = 1'b0;
        weightSwap = 1'b1;
        applyStimulus();
        weightSwap = 1'b0;
    endtask

    task automatic sample(input logic [7:0] x, input logic last, input logic [31:0] ps,
                          input logic psv);
        ifmapIn     = x;
        ifmapValid  = 1'b1;
        ifmapLast   = last;
        psumIn      = ps;
        psumValidIn = psv;
    endtask

    task automatic idle();
        ifmapValid  = 1'b0;
        ifmapLast   = 1'b0;
        psumValidIn = 1'b0;
    endtask

    initial begin
        pValid = 1'b0;
        clearInputs();
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;

        $display("[TB] mid-stream reset");
        loadAndSwap(8'h03);
        cfgSigned = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample(8'(k + 1), 1'b0, 32'd10, 1'b1);
            applyStimulus();
        end
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_valid", {31'h0, psumValidOut[0]}, 32'h0);
        rst = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("post_rst_valid", {31'h0, psumValidOut[0]}, 32'h0);
        end

        $display("[TB] WS signed and unsigned");
        loadAndSwap(8'hFD);
        cfgSigned = 1'b1;
        sample(8'd5, 1'b0, 32'd100, 1'b1);
        applyStimulus();
        idle();
        applyStimulus();
        checkOutput("ws_signed_psum", psumOut0, 32'd85);
        checkOutput("ws_signed_valid", {31'h0, psumValidOut[0]}, 32'h1);
        applyStimulus();
        checkOutput("ws_valid_pulse", {31'h0, psumValidOut[0]}, 32'h0);
        cfgSigned = 1'b0;
        sample(8'd5, 1'b0, 32'd100, 1'b1);
        applyStimulus();
        sample(8'd5, 1'b0, 32'd100, 1'b0);
        applyStimulus();
        checkOutput("ws_unsigned_psum", psumOut0, 32'd1365);
        idle();
        applyStimulus();
        checkOutput("ws_no_psum", psumOut0, 32'd1265);

        $display("[TB] ACC runs");
        loadAndSwap(8'd2);
        cfgSigned = 1'b1;
        cfgMode   = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            sample(8'(k), (k == 4), 32'hDEAD, 1'b1);
            applyStimulus();
        end
        idle();
        applyStimulus();
        checkOutput("acc_sum", psumOut0, 32'd20);
        checkOutput("acc_valid", {31'h0, psumValidOut[0]}, 32'h1);
        sample(8'd7, 1'b1, 32'h0, 1'b0);
        applyStimulus();
        idle();
        applyStimulus();
        checkOutput("acc_restart", psumOut0, 32'd14);
        cfgMode = 1'b0;

        $display("[TB] 16-bit overflow");
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        loadAndSwap(8'd127);
        cfgSigned = 1'b1;
        sample(8'd127, 1'b0, 32'h7FF0, 1'b1);
        applyStimulus();
        idle();
        applyStimulus();
        checkOutput("sat_psum", {16'h0, psumOut1}, 32'h7FFF);
        checkOutput("sat_ovf", {31'h0, ovfOut[1]}, 32'h1);
        checkOutput("wrap_psum", {16'h0, psumOut2}, 32'hBEF1);
        checkOutput("wrap_ovf", {31'h0, ovfOut[2]}, 32'h1);
        checkOutput("wide_no_ovf", {31'h0, ovfOut[0]}, 32'h0);

        $display("[TB] load and swap in the same cycle");
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        weightIn   = 8'd7;
        weightLoad = 1'b1;
        applyStimulus();
        weightIn   = 8'd9;
        weightSwap = 1'b1;
        cfgSigned  = 1'b1;
        sample(8'd3, 1'b0, 32'd0, 1'b1);
        applyStimulus();
        checkOutput("fwd_weight", {24'h0, weightOut}, 32'd9);
        checkOutput("fwd_load_swap", {30'h0, weightLoadOut, weightSwapOut}, 32'h3);
        weightLoad = 1'b0;
        weightSwap = 1'b0;
        applyStimulus();
        checkOutput("swap_cycle_old_w", psumOut0, 32'd0);
        idle();
        applyStimulus();
        checkOutput("after_swap_new_w", psumOut0, 32'd21);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 800; k++) begin
            rst         = ($urandom_range(0, 99) == 0);
            cfgSigned   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) cfgMode = ~cfgMode;
            weightIn    = 8'($urandom);
            weightLoad  = ($urandom_range(0, 3) == 0);
            weightSwap  = ($urandom_range(0, 4) == 0);
            ifmapIn     = 8'($urandom);
            ifmapValid  = ($urandom_range(0, 3) != 0);
            ifmapLast   = ($urandom_range(0, 4) == 0);
            psumIn      = ($urandom_range(0, 1) == 0) ? 32'($urandom)
                                                      : 32'($urandom_range(0, 65535));
            psumValidIn = 1'($urandom_range(0, 1));
            applyStimulus();
        end
        rst = 1'b0;
        clearInputs();
        applyStimulus();
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
